// File: rtl/luma_sync_gen_pkg.sv
// Shared types for the luma/sync generator: vertical FSM encoding and a log2 helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package luma_sync_gen_pkg;

   // Vertical interval sequence; encodings are fixed so they read the same in every chip variant
   typedef enum logic [1:0] {
      V_ACTIVE = 2'd0,
      PRE_EQ   = 2'd1,
      SERR     = 2'd2,
      POST_EQ  = 2'd3
   } vstate_t;

   // Exact log2 for the power-of-two boxcar depths (1, 2, 4, 8)
   function automatic int log2_depth(input int depth);
      int r;
      r = 0;
      while ((1 << r) < depth) r++;
      return r;
   endfunction

endpackage

// File: rtl/luma_sync_gen_if.sv
// Raster, timing-register and composite-luma signals between the raster source and the generator.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is sampled or produced each dot clock.
interface luma_sync_gen_if #(
   parameter int LUMA_W = 6,
   parameter int X_W    = 10,
   parameter int Y_W    = 9
);
   logic [X_W-1:0]    raster_x;
   logic [Y_W-1:0]    raster_y;
   logic [1:0]        chip;
   logic [LUMA_W-1:0] lumareg_o;
   logic [LUMA_W-1:0] blanking_level;
   logic [X_W-1:0]    line_len;
   logic [X_W-1:0]    half_line;
   logic [X_W-1:0]    hsync_start;
   logic [X_W-1:0]    hsync_end;
   logic [X_W-1:0]    hvisible_end;
   logic [X_W-1:0]    hvisible_start;
   logic [Y_W-1:0]    vvisible_end;
   logic [Y_W-1:0]    vblank_start;
   logic [Y_W-1:0]    vvisible_start;
   logic [X_W-1:0]    eq_width;
   logic [X_W-1:0]    se_width;
   logic [LUMA_W-1:0] luma;
   logic              csync;
   logic              vblank;
   logic              native_active;

   modport master (
      output raster_x, raster_y, chip, lumareg_o, blanking_level,
             line_len, half_line, hsync_start, hsync_end,
             hvisible_end, hvisible_start, vvisible_end, vblank_start,
             vvisible_start, eq_width, se_width,
      input  luma, csync, vblank, native_active
   );

   modport slave (
      input  raster_x, raster_y, chip, lumareg_o, blanking_level,
             line_len, half_line, hsync_start, hsync_end,
             hvisible_end, hvisible_start, vvisible_end, vblank_start,
             vvisible_start, eq_width, se_width,
      output luma, csync, vblank, native_active
   );
endinterface

// File: rtl/luma_sync_gen_boxcar.sv
// Boxcar average of the last DEPTH samples (shift history plus running sum); DEPTH=1 passes through.
// Latency: combinational for DEPTH=1, else 1 cycle (registered history and sum).
// Backpressure: none; accepts one sample per cycle unconditionally.
module luma_sync_gen_boxcar
   import luma_sync_gen_pkg::*;
#(
   parameter int W     = 6,
   parameter int DEPTH = 4
)(
   input  logic         clk_dot4x,
   input  logic         rst,
   input  logic [W-1:0] s_in,
   output logic [W-1:0] avg
);
   localparam int SH = log2_depth(DEPTH);
   localparam int SW = W + 3;

   generate
      if (DEPTH == 1) begin : g_bypass
         logic unused_clk_rst;
         assign unused_clk_rst = clk_dot4x ^ rst;
         assign avg = s_in;
      end else begin : g_avg
         logic [W-1:0]  hist [DEPTH];
         logic [SW-1:0] sum_q;

         // Shift in the new sample; the running sum adds it and drops the oldest one
         always_ff @(posedge clk_dot4x) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
               sum_q <= '0;
            end else begin
               hist[0] <= s_in;
               for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
               sum_q <= sum_q + SW'(s_in) - SW'(hist[DEPTH-1]);
            end
         end

         // Truncating divide by the tap count
         assign avg = W'(sum_q >> SH);
      end
   endgenerate

endmodule

// File: rtl/luma_sync_gen.sv
// Composite luma generator: raster position -> sync/blank/pixel sample select -> boxcar -> luma.
// Latency: csync/vblank/native_active 1 cycle; luma 1 cycle (AVG_DEPTH=1) else 2 cycles.
// Backpressure: none; free-running on the dot clock, one output sample per cycle.
module luma_sync_gen
   import luma_sync_gen_pkg::*;
#(
   parameter int LUMA_W    = 6,
   parameter int X_W       = 10,
   parameter int Y_W       = 9,
   parameter int AVG_DEPTH = 4,
   parameter int EQ_LINES  = 3,
   parameter int SE_LINES  = 3
)(
   input  logic           clk_dot4x,
   input  logic           rst,
   luma_sync_gen_if.slave bus
);
   localparam int PW   = X_W + 1;
   localparam int MAXL = (EQ_LINES > SE_LINES) ? EQ_LINES : SE_LINES;
   localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

   vstate_t           state;
   logic [CW-1:0]     line_cnt;
   logic [1:0]        chip_q;
   logic              chip_chg_q;
   logic [X_W-1:0]    x;
   logic [Y_W-1:0]    y;
   logic [PW-1:0]     x_w, ll_w, hl_w, hs_w, eqw_w, sew_w;
   logic [PW-1:0]     pos;
   logic              line_tick;
   logic              h_off, v_off, na_c;
   logic              sync_c;
   logic [LUMA_W-1:0] s;
   logic [LUMA_W-1:0] avg;

   assign x = bus.raster_x;
   assign y = bus.raster_y;

   // One extra bit so the wrapped position never truncates
   assign x_w   = {1'b0, x};
   assign ll_w  = {1'b0, bus.line_len};
   assign hl_w  = {1'b0, bus.half_line};
   assign hs_w  = {1'b0, bus.hsync_start};
   assign eqw_w = {1'b0, bus.eq_width};
   assign sew_w = {1'b0, bus.se_width};

   // Position measured from the sync-tip start; the x wrap folds in seamlessly
   always_comb begin
      pos = (x_w >= hs_w) ? (x_w - hs_w) : (x_w + ll_w - hs_w);
   end

   assign line_tick = (x == bus.hsync_start);

   // Register chip and the change compare; a change restarts the vertical sequence a cycle later
   always_ff @(posedge clk_dot4x) begin
      chip_q <= bus.chip;
      if (rst) chip_chg_q <= 1'b0;
      else     chip_chg_q <= (bus.chip != chip_q);
   end

   // Vertical interval FSM; vblank is registered alongside each state change
   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         state      <= V_ACTIVE;
         line_cnt   <= '0;
         bus.vblank <= 1'b0;
      end else if (chip_chg_q) begin
         state      <= V_ACTIVE;
         line_cnt   <= '0;
         bus.vblank <= 1'b0;
      end else if (line_tick) begin
         case (state)
            V_ACTIVE: begin
               if (y == bus.vblank_start) begin
                  state      <= PRE_EQ;
                  line_cnt   <= '0;
                  bus.vblank <= 1'b1;
               end
            end
            PRE_EQ: begin
               if (line_cnt == CW'(EQ_LINES - 1)) begin
                  state    <= SERR;
                  line_cnt <= '0;
               end else begin
                  line_cnt <= line_cnt + CW'(1);
               end
            end
            SERR: begin
               if (line_cnt == CW'(SE_LINES - 1)) begin
                  state    <= POST_EQ;
                  line_cnt <= '0;
               end else begin
                  line_cnt <= line_cnt + CW'(1);
               end
            end
            POST_EQ: begin
               if (line_cnt == CW'(EQ_LINES - 1)) begin
                  state      <= V_ACTIVE;
                  line_cnt   <= '0;
                  bus.vblank <= 1'b0;
               end else begin
                  line_cnt <= line_cnt + CW'(1);
               end
            end
            default: begin
               state      <= V_ACTIVE;
               line_cnt   <= '0;
               bus.vblank <= 1'b0;
            end
         endcase
      end
   end

   // Visible window: horizontal blank gap plus the vertical blank span across line boundaries
   always_comb begin
      h_off = (x >= bus.hvisible_end) && (x < bus.hvisible_start);
      v_off = ((y == bus.vvisible_end) && (x >= bus.hvisible_end)) ||
              ((y > bus.vvisible_end) && (y < bus.vvisible_start)) ||
              ((y == bus.vvisible_start) && (x <= bus.hvisible_start));
      na_c  = !h_off && !v_off;
   end

   // Sample select: sync tip (0), blanking, or pixel luma depending on the vertical state
   always_comb begin
      s      = bus.blanking_level;
      sync_c = 1'b0;
      case (state)
         PRE_EQ, POST_EQ: begin
            if ((pos < eqw_w) || ((pos >= hl_w) && (pos < hl_w + eqw_w))) begin
               s      = '0;
               sync_c = 1'b1;
            end
         end
         SERR: begin
            if (((pos >= hl_w - sew_w) && (pos < hl_w)) || (pos >= ll_w - sew_w)) begin
               s = bus.blanking_level;
            end else begin
               s      = '0;
               sync_c = 1'b1;
            end
         end
         V_ACTIVE: begin
            if ((x >= bus.hsync_start) && (x < bus.hsync_end)) begin
               s      = '0;
               sync_c = 1'b1;
            end else if (na_c) begin
               s = bus.lumareg_o;
            end
         end
         default: begin
            s      = bus.blanking_level;
            sync_c = 1'b0;
         end
      endcase
   end

   luma_sync_gen_boxcar #(
      .W     (LUMA_W),
      .DEPTH (AVG_DEPTH)
   ) u_boxcar (
      .clk_dot4x (clk_dot4x),
      .rst       (rst),
      .s_in      (s),
      .avg       (avg)
   );

   // Output registers toward the resistor ladder
   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         bus.luma          <= '0;
         bus.csync         <= 1'b0;
         bus.native_active <= 1'b0;
      end else begin
         bus.luma          <= avg;
         bus.csync         <= sync_c;
         bus.native_active <= na_c;
      end
   end

endmodule

// File: tb/tb_luma_sync_gen.sv
// Bench for luma_sync_gen: one AVG_DEPTH=1 instance plus an AVG_DEPTH=4 instance on the same raster.
// Latency: outputs are sampled 1 time unit after each clock edge.
// Backpressure: n/a.
module tb_luma_sync_gen;

   localparam int LL = 520;
   localparam int K_PRE  = 14 * LL + 9;   // first input seen in PRE_EQ
   localparam int K_SERR = 17 * LL + 9;
   localparam int K_POST = 20 * LL + 9;
   localparam int K_ACT  = 23 * LL + 9;

   logic       clk_dot4x = 1'b0;
   logic       rst;
   logic [9:0] raster_x;
   logic [8:0] raster_y;
   logic [1:0] chip;

   int errors = 0;
   int checks = 0;

   luma_sync_gen_if #(.LUMA_W(6), .X_W(10), .Y_W(9)) bus1 ();
   luma_sync_gen_if #(.LUMA_W(6), .X_W(10), .Y_W(9)) bus4 ();

   assign bus1.raster_x = raster_x;       assign bus4.raster_x = raster_x;
   assign bus1.raster_y = raster_y;       assign bus4.raster_y = raster_y;
   assign bus1.chip = chip;               assign bus4.chip = chip;
   assign bus1.lumareg_o = 6'd40;         assign bus4.lumareg_o = 6'd40;
   assign bus1.blanking_level = 6'd12;    assign bus4.blanking_level = 6'd12;
   assign bus1.line_len = 10'd520;        assign bus4.line_len = 10'd520;
   assign bus1.half_line = 10'd260;       assign bus4.half_line = 10'd260;
   assign bus1.hsync_start = 10'd8;       assign bus4.hsync_start = 10'd8;
   assign bus1.hsync_end = 10'd45;        assign bus4.hsync_end = 10'd45;
   assign bus1.hvisible_end = 10'd0;      assign bus4.hvisible_end = 10'd0;
   assign bus1.hvisible_start = 10'd96;   assign bus4.hvisible_start = 10'd96;
   assign bus1.vvisible_end = 9'd13;      assign bus4.vvisible_end = 9'd13;
   assign bus1.vblank_start = 9'd14;      assign bus4.vblank_start = 9'd14;
   assign bus1.vvisible_start = 9'd23;    assign bus4.vvisible_start = 9'd23;
   assign bus1.eq_width = 10'd18;         assign bus4.eq_width = 10'd18;
   assign bus1.se_width = 10'd37;         assign bus4.se_width = 10'd37;

   luma_sync_gen #(.AVG_DEPTH(1)) dut1 (.clk_dot4x(clk_dot4x), .rst(rst), .bus(bus1));
   luma_sync_gen #(.AVG_DEPTH(4)) dut4 (.clk_dot4x(clk_dot4x), .rst(rst), .bus(bus4));

   always #5 clk_dot4x = ~clk_dot4x;

   task automatic tick();
      @(posedge clk_dot4x);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s (y=%0d x=%0d): observed %0d expected %0d",
                tag, raster_y, raster_x, obs, exp);
      end
   endtask

   // Walk the raster from (y0,x0) up to but excluding (y1,x1)
   task automatic run_to(input int y0, input int x0, input int y1, input int x1);
      for (int k = y0 * LL + x0; k < y1 * LL + x1; k++) begin
         raster_y = 9'(k / LL);
         raster_x = 10'(k % LL);
         tick();
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_luma"},  32'(bus1.luma), 0);
      chk({tag, "_csync"}, 32'(bus1.csync), 0);
      chk({tag, "_vblank"}, 32'(bus1.vblank), 0);
      chk({tag, "_nact"},  32'(bus1.native_active), 0);
      chk({tag, "_luma4"}, 32'(bus4.luma), 0);
   endtask

   // Lines 13..23: whole vertical interval with every output checked each cycle
   task automatic run_frame();
      int    key, pos, exp_l, vb_cnt, first_key;
      int    exp_vb, exp_na;
      string ph;
      vb_cnt    = 0;
      first_key = -1;
      for (int y = 13; y <= 23; y++) begin
         for (int x = 0; x < LL; x++) begin
            raster_y = 9'(y);
            raster_x = 10'(x);
            tick();
            key    = y * LL + x;
            pos    = (x >= 8) ? (x - 8) : (x + LL - 8);
            exp_na = (y == 23 && x >= 97) ? 1 : 0;
            // vblank shows from the cycle after the line-14 tick until the cycle after the line-23 tick
            exp_vb = (key >= 14 * LL + 8 && key < 23 * LL + 8) ? 1 : 0;
            if (key < K_PRE || key >= K_ACT) ph = "act";
            else if (key < K_SERR)           ph = "pre";
            else if (key < K_POST)           ph = "serr";
            else                             ph = "post";
            if (ph == "pre" || ph == "post")
               exp_l = (pos < 18 || (pos >= 260 && pos < 278)) ? 0 : 12;
            else if (ph == "serr")
               exp_l = ((pos >= 223 && pos < 260) || pos >= 483) ? 12 : 0;
            else
               exp_l = (x >= 8 && x < 45) ? 0 : (exp_na != 0 ? 40 : 12);
            chk({ph, "_luma"},   32'(bus1.luma), exp_l);
            chk({ph, "_csync"},  32'(bus1.csync), (exp_l == 0) ? 1 : 0);
            chk({ph, "_vblank"}, 32'(bus1.vblank), exp_vb);
            chk({ph, "_nact"},   32'(bus1.native_active), exp_na);
            if (bus1.vblank === 1'b1) begin
               vb_cnt++;
               if (first_key < 0) first_key = key;
            end
         end
      end
      chk("vblank_len", vb_cnt, 9 * LL);
      chk("vblank_first", first_key, 14 * LL + 8);
   endtask

   initial begin
      int exp4 [6];
      int exp_l;
      exp4 = '{12, 19, 26, 33, 40, 40};

      // Reset state
      rst      = 1'b1;
      chip     = 2'd0;
      raster_y = 9'd100;
      raster_x = 10'd0;
      repeat (3) tick();
      chk_reset_outputs("rst");
      rst = 1'b0;

      // Visible line 100: blank, sync tip, blank, then pixel luma; boxcar step at x=96
      for (int x = 0; x < LL; x++) begin
         raster_x = 10'(x);
         tick();
         exp_l = (x >= 8 && x < 45) ? 0 : ((x >= 96) ? 40 : 12);
         chk("line_luma",  32'(bus1.luma), exp_l);
         chk("line_csync", 32'(bus1.csync), (x >= 8 && x < 45) ? 1 : 0);
         chk("line_nact",  32'(bus1.native_active), (x >= 96) ? 1 : 0);
         chk("line_vblank", 32'(bus1.vblank), 0);
         if (x >= 96 && x <= 101) chk("avg4_step", 32'(bus4.luma), exp4[x - 96]);
      end

      // Line 14 with x=8 skipped: no line tick, so no vertical interval
      raster_y = 9'd14;
      for (int x = 0; x <= 30; x++) begin
         if (x != 8) begin
            raster_x = 10'(x);
            tick();
            chk("noskip_vblank", 32'(bus1.vblank), 0);
         end
      end

      run_frame();

      // chip change mid-serration: vblank drops on the second edge, FSM back in V_ACTIVE
      run_to(14, 0, 18, 100);
      chk("serr_vblank", 32'(bus1.vblank), 1);
      raster_y = 9'd18;
      raster_x = 10'd100;
      chip     = 2'd1;
      tick();
      chk("chip_vblank_t1", 32'(bus1.vblank), 1);
      raster_x = 10'd101;
      tick();
      chk("chip_vblank_t2", 32'(bus1.vblank), 0);
      chk("chip_luma_t2", 32'(bus1.luma), 0);
      run_to(18, 102, 18, 108);
      raster_x = 10'd108;
      tick();
      chk("chip_act_luma", 32'(bus1.luma), 12);
      run_to(18, 109, 21, 0);
      chk("chip_stay_act", 32'(bus1.vblank), 0);

      // Reset pulse mid-pre-equalization, then a normal interval on the next pass
      run_to(14, 0, 15, 200);
      chk("pre_vblank", 32'(bus1.vblank), 1);
      chk("pre_luma", 32'(bus1.luma), 12);
      rst      = 1'b1;
      raster_y = 9'd15;
      raster_x = 10'd200;
      tick();
      chk_reset_outputs("midrst");
      rst = 1'b0;
      run_frame();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
